// File: rtl/fft_pkg.sv
// Shared constants, reader state encoding and index helpers for the FFT output reorder block.
package fft_pkg;

  localparam int unsigned FFT_N      = 64;
  localparam int unsigned FFT_LOG2N  = 6;
  localparam int unsigned FFT_DATA_W = 16;

  typedef enum logic [0:0] {
    RD_IDLE,
    RD_READ
  } rd_state_e;

  // The FFT core emits bins in bit-reversed order; this maps an arrival index to its bin.
  function automatic logic [5:0] bitrev6(input logic [5:0] x);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) begin
      r[i] = x[5-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample buffer: one synchronous write port, one asynchronous read port,
// both addressed by {bank, addr}.
module fft_pingpong_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG2N = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [LOG2N:0]   wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [LOG2N:0]   rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**(LOG2N+1)];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_output_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order through a ping-pong buffer,
// streaming completed frames out over a valid/ready interface.
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W,
  parameter int unsigned N      = FFT_N,
  parameter int unsigned LOG2N  = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LOG2N-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOG2N-1:0]  out_idx,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_first,
  output logic              out_last,
  output logic              overflow
);

  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic              drop_q, drop_d;
  logic              overflow_q, overflow_d;
  rd_state_e         state_q, state_d;
  logic [LOG2N-1:0]  rd_addr_q, rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [LOG2N-1:0]  out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_re_q, out_re_d;
  logic [DATA_W-1:0] out_im_q, out_im_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;

  logic                frame_start;
  logic                wr_en;
  logic [2*DATA_W-1:0] rd_data;
  logic                load;

  assign frame_start = in_valid && (in_idx == '0);
  // A frame start decides for itself whether it may write; other samples follow the drop flag.
  assign wr_en = in_valid && (frame_start ? !full_q[wr_bank_q] : !drop_q);

  fft_pingpong_ram #(
    .WIDTH(2 * DATA_W),
    .LOG2N(LOG2N)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr({wr_bank_q, bitrev6(in_idx)}),
    .wr_data({in_re, in_im}),
    .rd_addr({rd_bank_q, rd_addr_q}),
    .rd_data(rd_data)
  );

  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    drop_d      = drop_q;
    overflow_d  = overflow_q;
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    load        = 1'b0;

    if (frame_start) begin
      if (full_q[wr_bank_q]) begin
        drop_d     = 1'b1;
        overflow_d = 1'b1;
      end else begin
        drop_d = 1'b0;
      end
    end

    if (wr_en && (in_idx == LastIdx)) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    unique case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = RD_READ;
          rd_addr_d = '0;
        end
      end
      RD_READ: begin
        if (!out_valid_q || out_ready) begin
          load      = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == LastIdx) begin
            // Release this bank; continue straight into the other one if it is already waiting.
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            state_d           = full_q[~rd_bank_q] ? RD_READ : RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_idx_d   = rd_addr_q;
      out_re_d    = rd_data[2*DATA_W-1:DATA_W];
      out_im_d    = rd_data[DATA_W-1:0];
      out_first_d = (rd_addr_q == '0);
      out_last_d  = (rd_addr_q == LastIdx);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      drop_q      <= 1'b0;
      overflow_q  <= 1'b0;
      state_q     <= RD_IDLE;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      drop_q      <= drop_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
- Downstream of the 64-point FFT output counter stage.
- Captures the FFT result stream, which arrives in bit-reversed bin order, tagged by the counter's 6-bit index and data-valid.
- Writes samples into a 2-bank (ping-pong) 64-entry buffer at bit-reversed addresses.
- Streams each completed frame out in natural bin order (0..63) with a valid/ready handshake.

Parameters:
- DATA_W, 16, width of each real and imaginary component (two's complement).
- N, 64, points per frame; fixed, must equal 2**LOG2N.
- LOG2N, 6, index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample valid (driven by the output counter's datavalid).
- in_idx  in  LOG2N  sample index 0..63 in arrival order (the output counter's count).
- in_re  in  DATA_W  real part.
- in_im  in  DATA_W  imaginary part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output when high.
- out_idx  out  LOG2N  natural-order bin number of the output sample.
- out_re  out  DATA_W  real part, bin out_idx.
- out_im  out  DATA_W  imaginary part, bin out_idx.
- out_first  out  1  high with bin 0.
- out_last  out  1  high with bin 63.
- overflow  out  1  sticky; set when an input frame is dropped.

Behaviour:
- Reset values: out_valid, out_idx, out_re, out_im, out_first, out_last and overflow are all 0. Write bank = 0, read bank = 0, both full flags = 0, reader in IDLE, drop flag = 0. Memory contents are not cleared.
- Reset mid-operation: any partial input frame and any frame in flight are abandoned. Nothing is emitted until a new complete frame has been written.
- Write side:
  - A sample is written when in_valid = 1.
  - Address is bitrev(in_idx), i.e. {in_idx[0], in_idx[1], ..., in_idx[5]}, into the write bank.
  - Gaps (in_valid low) are allowed mid-frame; samples are written by index, not by arrival count.
- Frame start: a cycle with in_valid = 1 and in_idx = 0.
  - If the write bank's full flag is set, the frame is dropped: overflow is set, drop = 1, and writes are inhibited until the next frame start that finds a free bank.
  - Otherwise drop = 0 and the write proceeds.
- Frame complete: in_valid = 1, in_idx = 63, drop = 0.
  - Sets the write bank's full flag and toggles the write bank at that edge.
  - A repeated idx 0 before idx 63 restarts the frame in the same bank.
- Reader FSM (states IDLE, READ):
  - IDLE: if the read bank is full, go to READ with rd_addr = 0.
  - READ: the output register loads mem[rd_bank][rd_addr] when out_valid = 0 or out_ready = 1. On load: out_valid = 1, out_idx = rd_addr, out_first = (rd_addr == 0), out_last = (rd_addr == 63), rd_addr increments.
  - When address 63 is loaded: clear that bank's full flag and toggle the read bank. If the new read bank is full, stay in READ with rd_addr = 0 (no bubble); else go to IDLE.
  - out_valid falls when out_ready = 1 and there is no new load.
- Handshake:
  - While out_valid = 1 and out_ready = 0, all out_* signals hold stable.
  - A transfer occurs on any edge with out_valid = 1 and out_ready = 1.
- Latency: with out_ready = 1, bin 0 appears on out_* 2 cycles after the edge that writes idx 63 (edge E0 completes the frame, E1 enters READ, E2 loads bin 0). Thereafter one bin per cycle.
- Simultaneous events:
  - A write completing into bank A on the same edge the reader releases bank B: both take effect. The reader sees A full on the next evaluation.
  - Same-bank read/write overlap cannot occur, because full-flag gating forbids it.
- Arithmetic: none on data; values pass bit-exact. rd_addr wraps 63 -> 0.

Decomposition:
- Shared package fft_pkg:
  - FFT_N = 64, FFT_LOG2N = 6, FFT_DATA_W = 16.
  - Reader state encoding: RD_IDLE, RD_READ.
  - A bitrev6 function.
- One sub-module, fft_pingpong_ram: a 2 x 64 x (2*DATA_W) memory with one write port and one asynchronous read port, addressed by {bank, addr}.
- The FSM and flags stay in the top level.

Test Plan:
- Single frame: in_valid = 1 for 64 cycles, in_idx 0..63, in_re = in_idx, in_im = -in_idx, out_ready = 1 -> 64 consecutive outputs. out_idx n carries out_re = bitrev(n) (n = 1 -> 32, n = 3 -> 48, n = 63 -> 63); out_first only at n = 0, out_last only at n = 63; first out_valid 2 cycles after the idx-63 edge.
- Back-to-back frames: two frames with no gap, out_ready = 1 -> 128 contiguous out_valid cycles, second frame's bin 0 directly after the first's bin 63, overflow = 0.
- Input gaps: in_valid low for 5 cycles after idx 20 -> output identical to the single-frame case, starting 2 cycles after idx 63.
- Backpressure: out_ready low for 10 cycles at out_idx 17 -> out_* held at bin 17 with out_valid = 1; resumes at 18 with no loss or duplication.
- Overflow: out_ready held low while three frames are sent -> third frame dropped, overflow = 1 sticky. After releasing out_ready, exactly frames 1 and 2 are emitted.
- Reset mid-read: rst for 1 cycle at out_idx 20 -> all outputs 0 the next cycle, no output until a fresh full frame, whose bin 0 appears with correct data.
